// File: rtl/avmm_csr_pkg.sv
// Shared types and constants for the Avalon-MM CSR responder.
// be_merge applies a byte-enabled write on top of an existing word.
package avmm_csr_pkg;

    localparam int AVMM_ADDR_W = 17;
    localparam int AVMM_DATA_W = 32;
    localparam logic [AVMM_DATA_W-1:0] READ_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_ACCEPT  = 2'd2,
        ST_RD_PEND = 2'd3
    } state_t;

    function automatic logic [AVMM_DATA_W-1:0] be_merge(
        input logic [AVMM_DATA_W-1:0] old_w,
        input logic [AVMM_DATA_W-1:0] new_w,
        input logic [3:0]             be
    );
        logic [AVMM_DATA_W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/avmm_rdata_pipe.sv
// Fixed-latency read return pipe: data pushed at accept appears on valid_o/data_o
// exactly DEPTH cycles later; data_o holds the last returned word between strobes.
module avmm_rdata_pipe
    import avmm_csr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [AVMM_DATA_W-1:0] data_i,
    output logic                   last_o,
    output logic                   valid_o,
    output logic [AVMM_DATA_W-1:0] data_o
);

    logic [DEPTH-2:0]       vld_q;
    logic [AVMM_DATA_W-1:0] dat_q [DEPTH-1];
    logic                   valid_q;
    logic [AVMM_DATA_W-1:0] data_q;

    // Shift stages plus the registered output strobe and holding data register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= {(DEPTH-1){1'b0}};
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            for (int i = 0; i < DEPTH-1; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q[0] <= push_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH-1; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            valid_q <= vld_q[DEPTH-2];
            if (vld_q[DEPTH-2]) begin
                data_q <= dat_q[DEPTH-2];
            end else begin
                data_q <= data_q;
            end
        end
    end

    // High in the cycle before the strobe, so the FSM can release RD_PEND
    assign last_o  = vld_q[DEPTH-2];
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: NUM_REGS words (top word read-only status), programmable
// waitrequest stall, single outstanding fixed-latency read, saturating error counter.
module avmm_csr_responder
    import avmm_csr_pkg::*;
#(
    parameter int          NUM_REGS     = 16,
    parameter logic [16:0] BASE_ADDR    = 17'h0,
    parameter int          WAIT_CYCLES  = 1,
    parameter int          READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      avmm_write,
    input  logic                      avmm_read,
    input  logic [AVMM_ADDR_W-1:0]    avmm_address,
    input  logic [AVMM_DATA_W-1:0]    avmm_writedata,
    input  logic [3:0]                avmm_byteenable,
    output logic                      avmm_waitrequest,
    output logic [AVMM_DATA_W-1:0]    avmm_readdata,
    output logic                      avmm_readdatavalid,
    input  logic [AVMM_DATA_W-1:0]    status_in,
    output logic [32*NUM_REGS-1:0]    cfg_regs_out,
    output logic [7:0]                err_cnt
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WIDX_W = AVMM_ADDR_W - 2;
    localparam int RO_IDX = NUM_REGS - 1;

    state_t                 state_q;
    logic                   wreq_q;
    logic [3:0]             stall_cnt_q;
    logic [7:0]             err_q;
    logic [AVMM_DATA_W-1:0] regs_q [NUM_REGS];

    logic [WIDX_W-1:0]      widx_s;
    logic [IDX_W-1:0]       idx_s;
    logic                   hit_s;
    logic                   ro_s;
    logic                   req_s;
    logic                   accept_s;
    logic                   dispatch_s;
    logic                   wr_commit_s;
    logic                   rd_push_s;
    logic                   err_s;
    logic                   pipe_last_s;
    logic [AVMM_DATA_W-1:0] rd_data_s;
    logic                   unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^avmm_address[1:0];

    // Address decode, commit qualifiers and read-data selection
    always_comb begin
        widx_s      = avmm_address[AVMM_ADDR_W-1:2] - BASE_ADDR[AVMM_ADDR_W-1:2];
        hit_s       = (avmm_address[AVMM_ADDR_W-1:2] >= BASE_ADDR[AVMM_ADDR_W-1:2]) &&
                      (widx_s < WIDX_W'(NUM_REGS));
        idx_s       = widx_s[IDX_W-1:0];
        ro_s        = (idx_s == IDX_W'(RO_IDX));
        req_s       = avmm_read | avmm_write;
        accept_s    = (state_q == ST_ACCEPT);
        // RD_PEND hands over to new requests in its last cycle, exactly like IDLE
        dispatch_s  = (state_q == ST_IDLE) || ((state_q == ST_RD_PEND) && pipe_last_s);
        wr_commit_s = accept_s && avmm_write && hit_s && !ro_s;
        rd_push_s   = accept_s && avmm_read && !avmm_write;
        err_s       = accept_s && ((avmm_write && (!hit_s || ro_s || avmm_read)) ||
                                   (avmm_read && !avmm_write && !hit_s));
        if (!hit_s) begin
            rd_data_s = READ_ERR_DATA;
        end else if (ro_s) begin
            rd_data_s = status_in;
        end else begin
            rd_data_s = regs_q[idx_s];
        end
    end

    // Handshake FSM with registered waitrequest
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wreq_q      <= 1'b1;
            stall_cnt_q <= 4'h0;
        end else if (dispatch_s) begin
            if (!req_s) begin
                state_q <= ST_IDLE;
            end else if (WAIT_CYCLES > 0) begin
                state_q     <= ST_STALL;
                stall_cnt_q <= 4'(WAIT_CYCLES - 1);
            end else begin
                state_q <= ST_ACCEPT;
                wreq_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_STALL: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                    end else if (stall_cnt_q == 4'h0) begin
                        state_q <= ST_ACCEPT;
                        wreq_q  <= 1'b0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q - 4'h1;
                    end
                end
                ST_ACCEPT: begin
                    wreq_q  <= 1'b1;
                    state_q <= rd_push_s ? ST_RD_PEND : ST_IDLE;
                end
                ST_RD_PEND: begin
                    state_q <= ST_RD_PEND;
                end
                default: begin
                    state_q <= ST_IDLE;
                    wreq_q  <= 1'b1;
                end
            endcase
        end
    end

    // Register bank; the read-only slot is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wr_commit_s) begin
            regs_q[idx_s] <= be_merge(regs_q[idx_s], avmm_writedata, avmm_byteenable);
        end
    end

    // Saturating error counter, at most one step per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'h0;
        end else if (err_s && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'h1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cfg
            if (g == RO_IDX) begin : g_ro
                assign cfg_regs_out[32*g +: 32] = 32'h0;
            end else begin : g_rw
                assign cfg_regs_out[32*g +: 32] = regs_q[g];
            end
        end
    endgenerate

    avmm_rdata_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rdata_pipe (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rd_push_s),
        .data_i  (rd_data_s),
        .last_o  (pipe_last_s),
        .valid_o (avmm_readdatavalid),
        .data_o  (avmm_readdata)
    );

    assign avmm_waitrequest = wreq_q;
    assign err_cnt          = err_q;

endmodule

// File: tb/tb_avmm_csr_responder.sv
// Scoreboard bench for avmm_csr_responder: DUT0 uses W=1/L=2, DUT1 uses W=3/L=3.
module tb_avmm_csr_responder;
    import avmm_csr_pkg::*;

    typedef struct {
        int          d;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] addr_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;
    logic [31:0] status_s;
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic        wreq_s  [2];
    logic        rdv_s   [2];
    logic [31:0] rdata_s [2];
    logic [511:0] cfg_s  [2];
    logic [7:0]  err_s   [2];

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   lat_r, acc_r, exp_err;
    int   rdv_cnt [2];
    exp_t exp_q [$];
    int   due_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    avmm_csr_responder #(
        .NUM_REGS(16), .BASE_ADDR(17'h0), .WAIT_CYCLES(1), .READ_LATENCY(2)
    ) u_dut0 (
        .clk(clk), .rst(rst), .avmm_write(wr_s[0]), .avmm_read(rd_s[0]),
        .avmm_address(addr_s), .avmm_writedata(wdata_s), .avmm_byteenable(be_s),
        .avmm_waitrequest(wreq_s[0]), .avmm_readdata(rdata_s[0]),
        .avmm_readdatavalid(rdv_s[0]), .status_in(status_s),
        .cfg_regs_out(cfg_s[0]), .err_cnt(err_s[0])
    );

    avmm_csr_responder #(
        .NUM_REGS(16), .BASE_ADDR(17'h0), .WAIT_CYCLES(3), .READ_LATENCY(3)
    ) u_dut1 (
        .clk(clk), .rst(rst), .avmm_write(wr_s[1]), .avmm_read(rd_s[1]),
        .avmm_address(addr_s), .avmm_writedata(wdata_s), .avmm_byteenable(be_s),
        .avmm_waitrequest(wreq_s[1]), .avmm_readdata(rdata_s[1]),
        .avmm_readdatavalid(rdv_s[1]), .status_in(status_s),
        .cfg_regs_out(cfg_s[1]), .err_cnt(err_s[1])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Read-return monitor: accepted reads schedule a due cycle, strobes pop the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   due;
        for (int d = 0; d < 2; d++) begin
            if (!rst && !wreq_s[d] && rd_s[d] && !wr_s[d]) due_q.push_back(cyc + lat_of(d));
            if (rdv_s[d]) begin
                rdv_cnt[d]++;
                if (exp_q.size() == 0 || due_q.size() == 0) begin
                    check_val("rdv_unexpected", 32'h1, 32'h0);
                end else begin
                    e   = exp_q.pop_front();
                    due = due_q.pop_front();
                    check_val("rdv_dut", 32'(d), 32'(e.d));
                    check_val("rdata", rdata_s[d], e.data);
                    check_val("rdv_cycle", 32'(cyc), 32'(due));
                end
            end
        end
    end

    task automatic xfer(input int d, input logic r, input logic w, input int idx,
                        input logic [31:0] wd, input logic [3:0] b);
        int t0;
        bit done;
        addr_s  = 17'(idx * 4);
        wdata_s = wd;
        be_s    = b;
        rd_s[d] = r;
        wr_s[d] = w;
        t0      = cyc;
        done    = 1'b0;
        acc_r   = -1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!wreq_s[d]) begin
                acc_r = cyc;
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        lat_r   = acc_r - t0;
        if (!done) check_val("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_wr(input int d, input int idx, input logic [31:0] wd, input logic [3:0] b);
        xfer(d, 1'b0, 1'b1, idx, wd, b);
    endtask

    task automatic do_rd(input int d, input int idx, input logic [31:0] expd);
        exp_q.push_back('{d: d, data: expd});
        xfer(d, 1'b1, 1'b0, idx, 32'h0, 4'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            check_val("rdv_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            due_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_a, rdv_before;
        bit  saw_low;
        rst      = 1'b1;
        addr_s   = 17'h0;
        wdata_s  = 32'h0;
        be_s     = 4'h0;
        status_s = 32'hCAFE_0042;
        exp_err  = 0;
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = 1'b0;
            wr_s[d] = 1'b0;
            rdv_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_wreq", {31'h0, wreq_s[d]}, 32'h1);
            check_val("rst_rdv", {31'h0, rdv_s[d]}, 32'h0);
            check_val("rst_rdata", rdata_s[d], 32'h0);
            check_val("rst_err", {24'h0, err_s[d]}, 32'h0);
            check_val("rst_cfg", {31'h0, |cfg_s[d]}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Basic write/read with timing
        do_wr(0, 3, 32'h1234_5678, 4'hF);
        check_val("wr_lat", 32'(lat_r), 32'd2);
        check_val("wr_cfg3", cfg_s[0][32*3 +: 32], 32'h1234_5678);
        do_rd(0, 3, 32'h1234_5678);
        check_val("rd_lat", 32'(lat_r), 32'd2);
        drain();

        // Byte merge, readdata hold, empty byteenable
        do_wr(0, 3, 32'hAABB_CCDD, 4'b0101);
        do_rd(0, 3, 32'h12BB_56DD);
        drain();
        repeat (3) @(posedge clk);
        #1 check_val("rdata_hold", rdata_s[0], 32'h12BB_56DD);
        do_wr(0, 3, 32'hFFFF_FFFF, 4'h0);
        do_rd(0, 3, 32'h12BB_56DD);
        drain();
        check_val("be0_err", {24'h0, err_s[0]}, 32'(exp_err));

        // Miss read, RO write and readback
        do_rd(0, 16, 32'hDEAD_BEEF);
        drain();
        exp_err++;
        check_val("miss_err", {24'h0, err_s[0]}, 32'(exp_err));
        do_wr(0, 15, 32'h0BAD_F00D, 4'hF);
        exp_err++;
        check_val("ro_err", {24'h0, err_s[0]}, 32'(exp_err));
        check_val("ro_cfg", cfg_s[0][32*15 +: 32], 32'h0);
        do_rd(0, 15, 32'hCAFE_0042);
        drain();
        check_val("ro_rd_err", {24'h0, err_s[0]}, 32'(exp_err));

        // read and write together: write wins, error counted, no return
        rdv_before = rdv_cnt[0];
        xfer(0, 1'b1, 1'b1, 5, 32'h0000_00A5, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        exp_err++;
        check_val("rw_cfg5", cfg_s[0][32*5 +: 32], 32'h0000_00A5);
        check_val("rw_err", {24'h0, err_s[0]}, 32'(exp_err));
        check_val("rw_no_rdv", 32'(rdv_cnt[0]), 32'(rdv_before));

        // Back-to-back reads: second accepted the cycle after the first strobe
        do_rd(0, 3, 32'h12BB_56DD);
        acc_a = acc_r;
        do_rd(0, 5, 32'h0000_00A5);
        check_val("b2b_accept", 32'(acc_r - acc_a), 32'd3);
        drain();

        // Read data captured at accept, unaffected by the following write
        do_rd(0, 5, 32'h0000_00A5);
        do_wr(0, 5, 32'h0000_0011, 4'hF);
        drain();
        do_rd(0, 5, 32'h0000_0011);
        drain();

        // DUT1: dropped read and dropped write during stall
        rdv_before = rdv_cnt[1];
        saw_low = 1'b0;
        for (int k = 0; k < 2; k++) begin
            addr_s  = 17'd8;
            wdata_s = 32'hFFFF_FFFF;
            be_s    = 4'hF;
            rd_s[1] = (k == 0);
            wr_s[1] = (k == 1);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (!wreq_s[1]) saw_low = 1'b1;
                @(posedge clk);
                #1;
                if (c == 1) begin
                    rd_s[1] = 1'b0;
                    wr_s[1] = 1'b0;
                end
            end
        end
        check_val("drop_wreq", {31'h0, saw_low}, 32'h0);
        check_val("drop_rdv", 32'(rdv_cnt[1]), 32'(rdv_before));
        check_val("drop_cfg", {31'h0, |cfg_s[1]}, 32'h0);
        check_val("drop_err", {24'h0, err_s[1]}, 32'h0);

        // DUT1: full transfers with W=3, L=3
        do_wr(1, 0, 32'h5A5A_0001, 4'hF);
        check_val("w3_wr_lat", 32'(lat_r), 32'd4);
        do_rd(1, 0, 32'h5A5A_0001);
        check_val("w3_rd_lat", 32'(lat_r), 32'd4);
        drain();

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            do_wr(0, 20, 32'h0, 4'hF);
            if (exp_err < 255) exp_err++;
        end
        check_val("err_sat", {24'h0, err_s[0]}, 32'(exp_err));

        // Reset while a read is pending
        rdv_before = rdv_cnt[0];
        do_rd(0, 3, 32'h12BB_56DD);
        rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("rrst_no_rdv", 32'(rdv_cnt[0]), 32'(rdv_before));
        check_val("rrst_wreq", {31'h0, wreq_s[0]}, 32'h1);
        check_val("rrst_rdata", rdata_s[0], 32'h0);
        check_val("rrst_err", {24'h0, err_s[0]}, 32'h0);
        check_val("rrst_cfg", {31'h0, |cfg_s[0]}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
